ins_fetcher: RTL and testbench

Front-end fetch stage that feeds the Decoder with one RV32I instruction word and its PC per handshake.
- Issues single-word reads to the memory controller and buffers the returned words in a small instruction queue.
- Presents the queue head to the Decoder.
- On a Decoder redirect (clear + new address) it flushes the queue, squashes any in-flight read and restarts fetching at the new PC.

---
 rtl/ins_fetcher_pkg.sv | 28 ++
 rtl/ins_fetcher_if.sv | 31 +++
 rtl/ins_queue.sv | 79 +++++++
 rtl/ins_fetcher.sv | 113 +++++++++++
 tb/tb_ins_fetcher.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ins_fetcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ins_fetcher_pkg
// Brief    : Shared types and constants for the instruction fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
package ins_fetcher_pkg;

    localparam logic [31:0] c_pc_step   = 32'd4;
    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_WAIT = 2'b01,
        IF_DROP = 2'b10
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } iq_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & c_word_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ins_fetcher_if.sv
`default_nettype none
// ============================================================================
// Module   : ins_fetcher_if
// Brief    : Memory-controller request/response and Decoder hand-off signals.
// Revision : 1.0 - initial release
// ============================================================================
interface ins_fetcher_if;

    logic        mc_req_valid;
    logic [31:0] mc_req_addr;
    logic        mc_resp_valid;
    logic [31:0] mc_resp_data;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        dec_stall;
    logic        dec_clear;
    logic [31:0] dec_new_addr;

    modport master (
        output mc_req_valid, mc_req_addr, ins_ready, ins, pc,
        input  mc_resp_valid, mc_resp_data, dec_stall, dec_clear, dec_new_addr
    );

    modport slave (
        input  mc_req_valid, mc_req_addr, ins_ready, ins, pc,
        output mc_resp_valid, mc_resp_data, dec_stall, dec_clear, dec_new_addr
    );

endinterface
`default_nettype wire

// File: rtl/ins_queue.sv
`default_nettype none
// ============================================================================
// Module   : ins_queue
// Brief    : Register-based instruction FIFO with push/pop/flush and head view.
// Revision : 1.0 - initial release
// ============================================================================
module ins_queue
    import ins_fetcher_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  iq_entry_t               push_entry_i,
    input  logic                    pop_i,
    output iq_entry_t               head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    iq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en_i) begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
            end
        end
    end

    // Head is read straight out of the storage registers; stale data may sit
    // here when empty, so consumers must qualify it with empty_o.
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == c_depth);
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/ins_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : ins_fetcher
// Brief    : Fetch stage: single-outstanding word reads into a queue feeding the Decoder.
// Revision : 1.0 - initial release
// ============================================================================
module ins_fetcher
    import ins_fetcher_pkg::*;
#(
    parameter int unsigned IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    ins_fetcher_if.master fif
);

    localparam int unsigned      CNT_W   = $clog2(IQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(IQ_DEPTH);

    if_state_e   state_q;
    logic [31:0] fetch_pc_q;
    logic        req_valid_q;
    logic [31:0] req_addr_q;

    logic             w_pop;
    logic             w_push;
    logic             w_flush;
    logic             w_can_fetch;
    logic [31:0]      w_redirect_pc;
    iq_entry_t        w_push_entry;
    iq_entry_t        w_head;
    logic [CNT_W-1:0] w_q_count;
    logic             w_q_full;
    logic             w_q_empty;

    assign w_redirect_pc = word_align(fif.dec_new_addr);
    assign w_can_fetch   = (w_q_count < c_depth);
    assign w_flush       = rdy_in & fif.dec_clear;
    assign w_pop         = rdy_in & ~w_q_empty & ~fif.dec_stall & ~fif.dec_clear;
    assign w_push        = rdy_in & (state_q == IF_WAIT) & fif.mc_resp_valid & ~fif.dec_clear;
    assign w_push_entry  = '{pc: fetch_pc_q, ins: fif.mc_resp_data};

    ins_queue #(
        .DEPTH (IQ_DEPTH)
    ) u_queue (
        .clk_i        (clk_in),
        .rst_i        (rst_in),
        .en_i         (rdy_in),
        .flush_i      (w_flush),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .pop_i        (w_pop),
        .head_o       (w_head),
        .count_o      (w_q_count),
        .full_o       (w_q_full),
        .empty_o      (w_q_empty)
    );

    // A redirect always wins; a read still in flight must be drained in DROP
    // unless its response lands in the same cycle as the redirect.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IF_IDLE;
            fetch_pc_q  <= RESET_PC;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else if (rdy_in) begin
            req_valid_q <= 1'b0;
            if (fif.dec_clear) begin
                fetch_pc_q <= w_redirect_pc;
                case (state_q)
                    IF_WAIT, IF_DROP: state_q <= fif.mc_resp_valid ? IF_IDLE : IF_DROP;
                    default:          state_q <= IF_IDLE;
                endcase
            end else begin
                case (state_q)
                    IF_IDLE: begin
                        if (w_can_fetch) begin
                            req_valid_q <= 1'b1;
                            req_addr_q  <= fetch_pc_q;
                            state_q     <= IF_WAIT;
                        end
                    end
                    IF_WAIT: begin
                        if (fif.mc_resp_valid) begin
                            fetch_pc_q <= fetch_pc_q + c_pc_step;
                            state_q    <= IF_IDLE;
                        end
                    end
                    IF_DROP: begin
                        if (fif.mc_resp_valid) state_q <= IF_IDLE;
                    end
                    default: state_q <= IF_IDLE;
                endcase
            end
        end
    end

    // The request register holds while frozen, so the pulse is masked rather
    // than lost and reaches the memory controller on the first ready edge.
    assign fif.mc_req_valid = req_valid_q & rdy_in;
    assign fif.mc_req_addr  = req_addr_q;
    assign fif.ins_ready    = ~w_q_empty;
    assign fif.ins          = w_head.ins;
    assign fif.pc           = w_head.pc;

    a_push_never_full: assert property (@(posedge clk_in) disable iff (rst_in)
        w_push |-> (!w_q_full || w_pop));

endmodule
`default_nettype wire

// File: tb/tb_ins_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_fetcher
// Brief    : Directed self-checking bench for ins_fetcher with a latency-programmable memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_fetcher;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } pop_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    ins_fetcher_if bus ();

    ins_fetcher #(
        .IQ_DEPTH (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .fif    (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] req_log[$];
    pop_t        pop_log[$];
    int          resp_count = 0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int          slow_lat = 1;
    bit          bad_en = 1'b0;
    logic [31:0] bad_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // One clock: drive the memory response for the coming edge, log any pop,
    // advance, then record a request the edge accepted.
    task automatic cycle();
        bit          fired;
        bit          w_req;
        logic [31:0] a;
        fired = 1'b0;
        w_req = 1'b0;
        a     = '0;
        #1;
        bus.mc_resp_valid = 1'b0;
        if (!rst && rdy && pend && cnt == 0) begin
            fired             = 1'b1;
            bus.mc_resp_valid = 1'b1;
            bus.mc_resp_data  = (bad_en && paddr == bad_addr) ? 32'hDEAD_BEEF : mem_word(paddr);
            resp_count++;
        end
        if (!rst && rdy && bus.mc_req_valid) begin
            w_req = 1'b1;
            a     = bus.mc_req_addr;
        end
        if (!rst && rdy && bus.ins_ready && !bus.dec_stall && !bus.dec_clear) begin
            pop_log.push_back({bus.pc, bus.ins});
            chk("pop_data", bus.ins, mem_word(bus.pc));
        end
        @(posedge clk);
        #1;
        if (rst) begin
            pend = 1'b0;
        end else if (rdy) begin
            if (fired) pend = 1'b0;
            else if (pend && cnt > 0) cnt--;
            if (w_req) begin
                chk("one_outstanding", 32'(pend), 32'd0);
                pend  = 1'b1;
                paddr = a;
                cnt   = (a == slow_addr) ? slow_lat - 1 : 0;
                req_log.push_back(a);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        bus.dec_stall     = 1'b0;
        bus.dec_clear     = 1'b0;
        bus.dec_new_addr  = '0;
        bus.mc_resp_valid = 1'b0;
        bus.mc_resp_data  = '0;
        slow_addr = 32'hFFFF_FFFF;
        slow_lat  = 1;
        bad_en    = 1'b0;
        cycle();
        cycle();
        req_log.delete();
        pop_log.delete();
        resp_count = 0;
        pend       = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic wait_reqs(input string tag, input int n);
        for (int i = 0; i < 200 && req_log.size() < n; i++) cycle();
        chk(tag, 32'(req_log.size() >= n), 32'd1);
    endtask

    task automatic wait_pops(input string tag, input int n);
        for (int i = 0; i < 200 && pop_log.size() < n; i++) cycle();
        chk(tag, 32'(pop_log.size() >= n), 32'd1);
    endtask

    task automatic wait_resps(input string tag, input int n);
        for (int i = 0; i < 200 && resp_count < n; i++) cycle();
        chk(tag, 32'(resp_count >= n), 32'd1);
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_ins_ready", 32'(bus.ins_ready), 32'd0);
        chk("rst_ins", bus.ins, 32'h0);
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_req_valid", 32'(bus.mc_req_valid), 32'd0);
        chk("rst_req_addr", bus.mc_req_addr, 32'h0);

        // Free-running fetch with one-cycle memory
        wait_pops("t1_pops", 2);
        if (pop_log.size() >= 2) begin
            chk("t1_pop0_pc", pop_log[0].pc, 32'h0);
            chk("t1_pop1_pc", pop_log[1].pc, 32'h4);
        end
        wait_reqs("t1_reqs", 3);
        if (req_log.size() >= 3) begin
            chk("t1_req0", req_log[0], 32'h0);
            chk("t1_req1", req_log[1], 32'h4);
            chk("t1_req2", req_log[2], 32'h8);
        end

        // Stalled decoder fills the queue, then drains
        do_reset();
        bus.dec_stall = 1'b1;
        repeat (30) cycle();
        chk("t2_req_count", 32'(req_log.size()), 32'd4);
        if (req_log.size() >= 4) chk("t2_req3", req_log[3], 32'hC);
        chk("t2_ready", 32'(bus.ins_ready), 32'd1);
        chk("t2_head_pc", bus.pc, 32'h0);
        chk("t2_head_ins", bus.ins, 32'h1357_9BDF);
        repeat (10) cycle();
        chk("t2_no_req", 32'(req_log.size()), 32'd4);
        bus.dec_stall = 1'b0;
        wait_reqs("t2_resume", 5);
        if (req_log.size() >= 5) chk("t2_req4", req_log[4], 32'h10);
        wait_pops("t2_pops", 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("t2_pop_pc", pop_log[i].pc, 32'(4 * i));

        // Redirect while idle with two entries queued
        do_reset();
        bus.dec_stall = 1'b1;
        wait_resps("t3_resps", 2);
        chk("t3_ready_before", 32'(bus.ins_ready), 32'd1);
        bus.dec_clear    = 1'b1;
        bus.dec_new_addr = 32'h1002;
        cycle();
        bus.dec_clear = 1'b0;
        chk("t3_flushed", 32'(bus.ins_ready), 32'd0);
        chk("t3_no_req", 32'(bus.mc_req_valid), 32'd0);
        cycle();
        chk("t3_req_valid", 32'(bus.mc_req_valid), 32'd1);
        chk("t3_req_addr", bus.mc_req_addr, 32'h1000);
        wait_resps("t3_resp3", 3);
        chk("t3_head_pc", bus.pc, 32'h1000);
        chk("t3_head_ins", bus.ins, 32'h1357_8BDF);

        // Redirect while waiting; the slow response must be dropped
        do_reset();
        slow_addr = 32'h8;
        slow_lat  = 3;
        bad_en    = 1'b1;
        bad_addr  = 32'h8;
        wait_reqs("t4_req8", 3);
        if (req_log.size() >= 3) chk("t4_req2", req_log[2], 32'h8);
        bus.dec_clear    = 1'b1;
        bus.dec_new_addr = 32'h200;
        cycle();
        bus.dec_clear = 1'b0;
        wait_reqs("t4_req200", 4);
        if (req_log.size() >= 4) chk("t4_req3", req_log[3], 32'h200);
        wait_pops("t4_pops", 3);
        if (pop_log.size() >= 3) begin
            chk("t4_pop2_pc", pop_log[2].pc, 32'h200);
            chk("t4_pop2_ins", pop_log[2].ins, 32'h1357_99DF);
        end

        // Redirect coinciding with the response
        do_reset();
        wait_reqs("t5_req0", 1);
        bus.dec_clear    = 1'b1;
        bus.dec_new_addr = 32'h3000;
        cycle();
        bus.dec_clear = 1'b0;
        chk("t5_resp_same_cycle", 32'(resp_count), 32'd1);
        chk("t5_flushed", 32'(bus.ins_ready), 32'd0);
        cycle();
        chk("t5_req_valid", 32'(bus.mc_req_valid), 32'd1);
        chk("t5_req_addr", bus.mc_req_addr, 32'h3000);
        wait_pops("t5_pops", 1);
        if (pop_log.size() >= 1) chk("t5_pop0_pc", pop_log[0].pc, 32'h3000);

        // Global ready low mid-WAIT
        do_reset();
        bus.dec_stall = 1'b1;
        slow_addr     = 32'h4;
        slow_lat      = 2;
        wait_reqs("t6_req4", 2);
        rdy           = 1'b0;
        bus.dec_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t6_req_valid", 32'(bus.mc_req_valid), 32'd0);
            chk("t6_req_addr", bus.mc_req_addr, 32'h4);
            chk("t6_ready", 32'(bus.ins_ready), 32'd1);
            chk("t6_pc", bus.pc, 32'h0);
        end
        rdy           = 1'b1;
        bus.dec_stall = 1'b1;
        wait_resps("t6_resp", 2);
        chk("t6_head_pc", bus.pc, 32'h0);
        bus.dec_stall = 1'b0;
        wait_pops("t6_pops", 2);
        if (pop_log.size() >= 2) begin
            chk("t6_pop0_pc", pop_log[0].pc, 32'h0);
            chk("t6_pop1_pc", pop_log[1].pc, 32'h4);
        end

        // Reset asserted while dropping a squashed read
        do_reset();
        slow_addr = 32'h0;
        slow_lat  = 4;
        wait_reqs("t7_req0", 1);
        bus.dec_clear    = 1'b1;
        bus.dec_new_addr = 32'h500;
        cycle();
        bus.dec_clear = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        cycle();
        chk("t7_ready", 32'(bus.ins_ready), 32'd0);
        chk("t7_req_valid", 32'(bus.mc_req_valid), 32'd0);
        chk("t7_req_addr", bus.mc_req_addr, 32'h0);
        slow_addr = 32'hFFFF_FFFF;
        req_log.delete();
        pop_log.delete();
        rst = 1'b0;
        wait_reqs("t7_req_after", 1);
        if (req_log.size() >= 1) chk("t7_reset_pc", req_log[0], 32'h0);
        wait_pops("t7_pops", 1);
        if (pop_log.size() >= 1) chk("t7_pop0_pc", pop_log[0].pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
